la_capture_recorder: RTL and testbench

LA_CAPTURE_RECORDER -- requirements
Module: la_capture_recorder

---
 rtl/la_capture_recorder.sv | 120 ++++++++++++
 tb/tb_la_capture_recorder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/la_capture_recorder.sv
// Logic-analyzer capture buffer: arms, fills a pre-trigger window, waits for the trigger,
// then records the post-trigger tail into a circular RAM read back in chronological order.
module la_capture_recorder #(
  parameter int SAMPLE_DEPTH      = 4096,
  parameter int TOTAL_PROBE_WIDTH = 7
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [TOTAL_PROBE_WIDTH-1:0]    probes,
  input  logic                            trigger,
  input  logic                            arm,
  input  logic [$clog2(SAMPLE_DEPTH)-1:0] trigger_loc,
  output logic [2:0]                      state,
  output logic                            done,
  input  logic [$clog2(SAMPLE_DEPTH)-1:0] rd_addr,
  output logic [TOTAL_PROBE_WIDTH-1:0]    rd_data
);

  localparam int AW = $clog2(SAMPLE_DEPTH);
  localparam logic [AW:0]   DEPTH_M1  = (AW+1)'(SAMPLE_DEPTH - 1);
  localparam logic [AW-1:0] PRE_MAX   = AW'(SAMPLE_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MOVE     = 3'd1,
    S_INPOS    = 3'd2,
    S_CAPTURE  = 3'd3,
    S_CAPTURED = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          pre_q, pre_d;
  logic [AW-1:0]          start_q, start_d;
  logic [AW:0]            wcnt_q, wcnt_d;
  logic [AW:0]            post_q, post_d;
  logic                   we;
  logic [AW:0]            post_tgt;
  logic [AW-1:0]          rd_idx;
  logic [TOTAL_PROBE_WIDTH-1:0] rd_data_q;

  logic [TOTAL_PROBE_WIDTH-1:0] mem [SAMPLE_DEPTH];

  // Post-trigger samples needed so the window totals exactly SAMPLE_DEPTH.
  assign post_tgt = DEPTH_M1 - {1'b0, pre_q};
  assign rd_idx   = start_q + rd_addr;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    pre_d    = pre_q;
    start_d  = start_q;
    wcnt_d   = wcnt_q;
    post_d   = post_q;
    we       = 1'b0;
    case (state_q)
      S_IDLE, S_CAPTURED: begin
        if (arm) begin
          pre_d    = trigger_loc;
          wr_ptr_d = '0;
          wcnt_d   = '0;
          post_d   = '0;
          state_d  = (trigger_loc != '0) ? S_MOVE : S_INPOS;
        end
      end
      S_MOVE: begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        wcnt_d   = wcnt_q + 1'b1;
        if (wcnt_d == {1'b0, pre_q}) state_d = S_INPOS;
      end
      S_INPOS: begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (trigger) begin
          start_d = wr_ptr_q - pre_q;
          post_d  = '0;
          state_d = (pre_q == PRE_MAX) ? S_CAPTURED : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        post_d   = post_q + 1'b1;
        if (post_d == post_tgt) state_d = S_CAPTURED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      pre_q     <= '0;
      start_q   <= '0;
      wcnt_q    <= '0;
      post_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      pre_q     <= pre_d;
      start_q   <= start_d;
      wcnt_q    <= wcnt_d;
      post_q    <= post_d;
      rd_data_q <= mem[rd_idx];
    end
  end

  // RAM is deliberately left out of reset so a capture survives a reset pulse.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= probes;
  end

  assign state   = state_q;
  assign done    = (state_q == S_CAPTURED);
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_la_capture_recorder.sv
// Bench for la_capture_recorder: probes carry a running count, a reference model derives
// the expected state sequence and capture window from the logged trigger/probe history.
module tb_la_capture_recorder;
  localparam int D  = 16;
  localparam int W  = 7;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trigger = 1'b0;
  logic          arm = 1'b0;
  logic [W-1:0]  probes = '0;
  logic [AW-1:0] trigger_loc = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [2:0]    state;
  logic          done;
  logic [W-1:0]  rd_data;

  int vectors = 0;
  int miscompares = 0;
  int ecnt = 0;
  int c = 0;
  logic [W-1:0] hist [0:4095];
  logic         trg_log [0:4095];

  always #5 clk = ~clk;

  la_capture_recorder #(.SAMPLE_DEPTH(D), .TOTAL_PROBE_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .probes(probes), .trigger(trigger), .arm(arm),
    .trigger_loc(trigger_loc), .state(state), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // One active edge: log what the DUT sampled, then advance the probe count.
  task automatic tick;
    @(posedge clk);
    hist[ecnt]    = probes;
    trg_log[ecnt] = trigger;
    ecnt++;
    #1;
    c++;
    probes = W'(c);
  endtask

  task automatic set_c(input int v);
    c = v;
    probes = W'(c);
  endtask

  task automatic rd_chk(input string tag, input int addr, input int exp);
    rd_addr = AW'(addr);
    tick;
    chk(tag, 32'(rd_data), exp);
  endtask

  // mode 0: single pulse at arm edge + toff; 1: held high; 2: random.
  // rst_at>0: pull reset that many edges into the post-trigger phase.
  task automatic capture(input int loc, input int mode, input int toff, input int rst_at);
    int A, T, e, exp_st;
    bit tf, aborted;
    trigger_loc = AW'(loc);
    arm = 1'b1;
    trigger = (mode == 1);
    tick;
    A = ecnt - 1;
    arm = 1'b0;
    tf = 0; T = 0; aborted = 0;
    exp_st = (loc > 0) ? 1 : 2;
    chk("arm_state", 32'(state), exp_st);
    for (int n = 0; n < 200; n++) begin
      e = ecnt;
      case (mode)
        0:       trigger = (e == A + toff);
        1:       trigger = 1'b1;
        default: trigger = ($urandom_range(0, 2) == 0);
      endcase
      arm = ($urandom_range(0, 3) == 0);
      tick;
      if (!tf && e >= A + loc + 1 && trg_log[e]) begin tf = 1; T = e; end
      if (!tf) exp_st = (e < A + loc) ? 1 : 2;
      else     exp_st = (e >= T + (D - 1 - loc)) ? 4 : 3;
      chk("state", 32'(state), exp_st);
      chk("done", 32'(done), 32'(exp_st == 4));
      if (rst_at > 0 && exp_st == 3 && e >= T + rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd", 32'(rd_data), 0);
        arm = 1'b0; trigger = 1'b0;
        tick;
        #2 rst_n = 1'b1;
        tick;
        chk("post_rst_idle", 32'(state), 0);
        aborted = 1;
        break;
      end
      if (exp_st == 4) break;
    end
    arm = 1'b0;
    trigger = 1'b0;
    if (!aborted) begin
      if (exp_st != 4) chk("timeout", 32'(state), 4);
      else
        for (int i = 0; i < D; i++) rd_chk("rd", i, 32'(hist[T - loc + i]));
    end
  endtask

  initial begin
    #2;
    chk("reset_state", 32'(state), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_rd", 32'(rd_data), 0);
    #10 rst_n = 1'b1;
    tick;
    chk("idle_after_reset", 32'(state), 0);

    set_c(10); capture(4, 0, 10, 0);
    rd_chk("t28_a4", 4, 20);
    rd_chk("t28_a0", 0, 16);

    set_c(5); capture(0, 0, 1, 0);
    rd_chk("t29_a0", 0, 6);
    rd_chk("t29_a15", 15, 21);

    set_c(50); capture(4, 1, 0, 0);
    rd_chk("t30_a4", 4, 55);

    set_c(20); capture(15, 0, 20, 0);
    rd_chk("t31_a15", 15, 40);
    rd_chk("t31_a0", 0, 25);

    for (int k = 0; k < 6; k++) capture($urandom_range(0, D - 1), 2, 0, 0);
    for (int k = 0; k < 3; k++) begin
      int l;
      l = $urandom_range(0, D - 1);
      capture(l, 0, l + 1 + $urandom_range(0, 6), 0);
    end

    capture(7, 1, 0, 3);
    capture(5, 2, 0, 0);
    capture(2, 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
